// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared definitions for the multicycle main control FSM.
//   state_t    - 4-bit binary state encoding, FETCH..UNKNOWN (codes 11-15 unused)
//   SRCB_*     - ALUSrcB mux encodings
//   RES_*      - ResultSrc mux encodings
//   OP_*       - instruction class carried in Op (instr[27:26])
//   ctrl_t     - control word produced by the state decoder
//   fetch_selects() - FETCH mux selects with every strobe low (used while in reset)
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       instrdone;
    logic       illegalop;
  } ctrl_t;

  function automatic ctrl_t fetch_selects();
    ctrl_t c;
    c           = '0;
    c.alusrca   = 1'b1;
    c.alusrcb   = SRCB_FOUR;
    c.resultsrc = RES_ALU;
    return c;
  endfunction

endpackage

// File: rtl/mainfsm_outdec.sv
// mainfsm_outdec: purely combinational state -> control word decoder.
//   state     - current FSM state
//   mem_ready - effective memory-ready (already forced high when wait states are disabled)
//   ctrl      - control word; unused state codes decode to all zeros
module mainfsm_outdec
  import arm_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.adrsrc    = 1'b0;
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.aluop     = 1'b0;
        ctrl.resultsrc = RES_ALU;
        // IR load and PC+4 only on the cycle the fetch completes
        ctrl.irwrite   = mem_ready;
        ctrl.nextpc    = mem_ready;
      end
      DECODE: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALU;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = SRCB_EXTIMM;
        ctrl.aluop   = 1'b0;
      end
      MEMRD: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regw      = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      MEMWR: begin
        // MemW is held through every wait cycle; the store retires on MemReady
        ctrl.adrsrc    = 1'b1;
        ctrl.memw      = 1'b1;
        ctrl.instrdone = mem_ready;
      end
      EXECUTER: begin
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = 1'b1;
      end
      EXECUTEI: begin
        ctrl.alusrcb = SRCB_EXTIMM;
        ctrl.aluop   = 1'b1;
      end
      ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regw      = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrcb   = SRCB_EXTIMM;
        ctrl.resultsrc = RES_ALU;
        ctrl.branch    = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      UNKNOWN: begin
        ctrl.illegalop = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// mainfsm: multicycle main control FSM (fetch / decode / execute / memory / writeback).
// Emits unconditioned RegW / MemW / NextPC / Branch requests; condition gating and
// flag registers live downstream.
//
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   Op, Funct          - instr[27:26] and instr[25:20]; Funct[5]=I, Funct[0]=L
//   MemReady           - memory completes the current access this cycle
//   IRWrite, NextPC, RegW, MemW, Branch - write/branch request strobes
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp - datapath selects
//   InstrDone          - pulse on the final cycle of every instruction
//   IllegalOp          - pulse while in UNKNOWN
//   dbg_state          - current state code, for observation only
//
// Memory handshake: the FSM presents an access (instruction fetch in FETCH, data
// read in MEMRD, data write with MemW in MEMWR) and holds it unchanged every cycle
// until MemReady=1; the access completes in the cycle MemReady is high and the FSM
// advances on that edge. MemReady in any other state is ignored. With
// MEM_WAIT_EN=0 MemReady is treated as constantly high.
module mainfsm
  import arm_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic [3:0] dbg_state
);

  state_t state;
  logic   mem_ready;
  ctrl_t  dec_ctrl;
  ctrl_t  ctrl;

  // Only I (bit 5) and L (bit 0) steer the sequence; the rest belong to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  assign mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          case (Op)
            OP_MEM:  state <= MEMADR;
            OP_DP:   state <= Funct[5] ? EXECUTEI : EXECUTER;
            OP_BR:   state <= BRANCH;
            default: state <= UNKNOWN;
          endcase
        end
        MEMADR:   state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:    if (mem_ready) state <= MEMWB;
        MEMWR:    if (mem_ready) state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        MEMWB:    state <= FETCH;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        UNKNOWN:  state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  mainfsm_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (dec_ctrl)
  );

  // Reset drops every strobe in the same cycle (abandoning any pending store)
  // and parks the muxes on their FETCH settings.
  always_comb begin
    ctrl = dec_ctrl;
    if (reset) ctrl = fetch_selects();
  end

  assign IRWrite   = ctrl.irwrite;
  assign NextPC    = ctrl.nextpc;
  assign RegW      = ctrl.regw;
  assign MemW      = ctrl.memw;
  assign Branch    = ctrl.branch;
  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign ALUOp     = ctrl.aluop;
  assign InstrDone = ctrl.instrdone;
  assign IllegalOp = ctrl.illegalop;
  assign dbg_state = state;

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: scoreboard bench for mainfsm. The driver walks each instruction
// through its phases as the instruction set describes them, pushing the expected
// per-cycle control word and the expected instruction latency; a negedge monitor
// pops and compares against two DUTs (wait states enabled / disabled).
module tb_mainfsm;
  import arm_ctrl_pkg::*;

  localparam int W = 18;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                P_EXR, P_EXI, P_ALUWB, P_BR, P_UND} step_t;

  typedef struct packed {
    logic [3:0] st;
    logic       irwrite;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       instrdone;
    logic       illegalop;
  } obs_t;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;

  logic       irwrite, nextpc, regw, memw, branch, adrsrc, alusrca, aluop, instrdone, illegalop;
  logic [1:0] alusrcb, resultsrc;
  logic [3:0] dbg_state;
  logic       irwrite0, nextpc0, regw0, memw0, branch0, adrsrc0, alusrca0, aluop0, instrdone0, illegalop0;
  logic [1:0] alusrcb0, resultsrc0;
  logic [3:0] dbg_state0;

  always #5 clk = ~clk;

  mainfsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .MemReady(mem_ready),
    .IRWrite(irwrite), .NextPC(nextpc), .RegW(regw), .MemW(memw), .Branch(branch),
    .AdrSrc(adrsrc), .ALUSrcA(alusrca), .ALUSrcB(alusrcb), .ResultSrc(resultsrc),
    .ALUOp(aluop), .InstrDone(instrdone), .IllegalOp(illegalop), .dbg_state(dbg_state)
  );

  mainfsm #(.MEM_WAIT_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .MemReady(1'b0),
    .IRWrite(irwrite0), .NextPC(nextpc0), .RegW(regw0), .MemW(memw0), .Branch(branch0),
    .AdrSrc(adrsrc0), .ALUSrcA(alusrca0), .ALUSrcB(alusrcb0), .ResultSrc(resultsrc0),
    .ALUOp(aluop0), .InstrDone(instrdone0), .IllegalOp(illegalop0), .dbg_state(dbg_state0)
  );

  logic [W-1:0] got_main, got_nowait;
  assign got_main   = {dbg_state, irwrite, nextpc, regw, memw, branch, adrsrc, alusrca,
                       alusrcb, resultsrc, aluop, instrdone, illegalop};
  assign got_nowait = {dbg_state0, irwrite0, nextpc0, regw0, memw0, branch0, adrsrc0, alusrca0,
                       alusrcb0, resultsrc0, aluop0, instrdone0, illegalop0};

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           cyc_no = 0;
  int           lat_cnt = 0;
  bit           chk0 = 1'b0;
  bit           force_ready = 1'b0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%h (state=%0d) exp=%h (state=%0d)",
                  name, cyc_no, got, got[W-1 -: 4], exp, exp[W-1 -: 4]);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc_no, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic obs_t exp_word(input step_t s, input logic rdy);
    obs_t o;
    o = '0;
    case (s)
      P_FETCH:  begin o.st = FETCH; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
                      o.irwrite = rdy; o.nextpc = rdy; end
      P_DECODE: begin o.st = DECODE; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
      P_MEMADR: begin o.st = MEMADR; o.alusrcb = 2'b01; end
      P_MEMRD:  begin o.st = MEMRD; o.adrsrc = 1'b1; end
      P_MEMWB:  begin o.st = MEMWB; o.resultsrc = 2'b01; o.regw = 1'b1; o.instrdone = 1'b1; end
      P_MEMWR:  begin o.st = MEMWR; o.adrsrc = 1'b1; o.memw = 1'b1; o.instrdone = rdy; end
      P_EXR:    begin o.st = EXECUTER; o.aluop = 1'b1; end
      P_EXI:    begin o.st = EXECUTEI; o.alusrcb = 2'b01; o.aluop = 1'b1; end
      P_ALUWB:  begin o.st = ALUWB; o.regw = 1'b1; o.instrdone = 1'b1; end
      P_BR:     begin o.st = BRANCH; o.alusrcb = 2'b01; o.resultsrc = 2'b10; o.branch = 1'b1;
                      o.instrdone = 1'b1; end
      default:  begin o.st = UNKNOWN; o.illegalop = 1'b1; o.instrdone = 1'b1; end
    endcase
    return o;
  endfunction

  // In reset: strobes low, FETCH selects, state is whatever the register holds.
  function automatic obs_t reset_word(input state_t s);
    obs_t o;
    o = '0;
    o.st = s; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
    return o;
  endfunction

  function automatic logic rnd_ready();
    return force_ready ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input logic rst, input logic rdy, input logic [W-1:0] e);
    reset     = rst;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // fw: fetch wait cycles, mw: data-memory wait cycles,
  // abort: reset raised after that many MEMWR wait cycles (-1 = never)
  task automatic run_instr(input logic [1:0] iop, input logic [5:0] ifn,
                           input int fw, input int mw, input int abort);
    step_t r[5];
    int    n;
    int    lat;
    bit    aborts;
    r[0] = P_FETCH;
    r[1] = P_DECODE;
    r[2] = P_UND; r[3] = P_UND; r[4] = P_UND;
    n    = 3;
    case (iop)
      2'b01: begin
        r[2] = P_MEMADR;
        if (ifn[0]) begin r[3] = P_MEMRD; r[4] = P_MEMWB; n = 5; end
        else begin r[3] = P_MEMWR; n = 4; end
      end
      2'b00: begin r[2] = ifn[5] ? P_EXI : P_EXR; r[3] = P_ALUWB; n = 4; end
      2'b10: r[2] = P_BR;
      default: r[2] = P_UND;
    endcase
    // zero-wait latency table: LDR 5, STR 4, DP 4, B 3, undefined 3
    if (iop == 2'b01) lat = (ifn[0] ? 5 : 4) + mw;
    else if (iop == 2'b00) lat = 4;
    else lat = 3;
    lat += fw;
    aborts = (iop == 2'b01) && !ifn[0] && (abort >= 0) && (abort < mw);
    if (!aborts) lat_q.push_back(lat);

    for (int i = 0; i < n; i++) begin
      if (r[i] == P_DECODE) begin op = iop; funct = ifn; end
      if (r[i] == P_FETCH || r[i] == P_MEMRD || r[i] == P_MEMWR) begin
        int w;
        w = (r[i] == P_FETCH) ? fw : mw;
        for (int k = 0; k < w; k++) begin
          if (r[i] == P_FETCH) begin op = 2'($urandom_range(0, 3)); funct = 6'($urandom); end
          if (r[i] == P_MEMWR && k == abort) begin
            cyc(1'b1, 1'b0, reset_word(MEMWR));
            return;
          end
          cyc(1'b0, 1'b0, exp_word(r[i], 1'b0));
        end
        if (r[i] == P_FETCH) begin op = 2'($urandom_range(0, 3)); funct = 6'($urandom); end
        cyc(1'b0, 1'b1, exp_word(r[i], 1'b1));
      end else begin
        cyc(1'b0, rnd_ready(), exp_word(r[i], 1'b0));
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctrl_word", got_main, e);
      if (chk0) check("ctrl_word_nowait", got_nowait, e);
    end
    if (reset) begin
      lat_cnt = 0;
    end else begin
      lat_cnt++;
      if (instrdone) begin
        if (lat_q.size() == 0) check_int("latency_unexpected_done", 1, 0);
        else check_int("latency", lat_cnt, lat_q.pop_front());
        lat_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; op = 2'b00; funct = 6'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // two reset cycles; MemReady high must not leak IRWrite/NextPC
    cyc(1'b1, 1'b1, reset_word(FETCH));
    cyc(1'b1, 1'b0, reset_word(FETCH));

    force_ready = 1'b1;
    run_instr(2'b00, 6'b101000, 0, 0, -1);   // ADD immediate, zero wait
    force_ready = 1'b0;
    run_instr(2'b01, 6'b011001, 0, 3, -1);   // LDR, 3 wait cycles in MEMRD
    run_instr(2'b01, 6'b011000, 0, 2, -1);   // STR, 2 wait cycles in MEMWR
    run_instr(2'b10, 6'b000000, 2, 0, -1);   // B, fetch held 2 cycles
    run_instr(2'b11, 6'b110101, 0, 0, -1);   // undefined
    run_instr(2'b01, 6'b011000, 1, 3, 1);    // STR abandoned by reset mid-wait
    run_instr(2'b00, 6'b000100, 1, 0, -1);   // DP register after the abort

    for (int t = 0; t < 40; t++) begin
      logic [1:0] iop;
      logic [5:0] ifn;
      int         ab;
      iop = 2'($urandom_range(0, 3));
      ifn = 6'($urandom);
      ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_instr(iop, ifn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), ab);
    end
    run_instr(2'b00, 6'b101000, 0, 0, -1);

    // zero-wait configuration: MemReady tied low on dut0, held high on dut
    force_ready = 1'b1;
    cyc(1'b1, 1'b1, reset_word(FETCH));
    chk0 = 1'b1;
    cyc(1'b1, 1'b1, reset_word(FETCH));
    run_instr(2'b01, 6'b011001, 0, 0, -1);   // LDR in 5 cycles
    run_instr(2'b01, 6'b011000, 0, 0, -1);   // STR in 4
    run_instr(2'b00, 6'b000000, 0, 0, -1);   // DP register
    run_instr(2'b10, 6'b000000, 0, 0, -1);   // B
    chk0 = 1'b0;

    check_int("lat_q_drained", lat_q.size(), 0);
    check_int("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc_no);
    $fatal(1);
  end

endmodule
